compressed_packer: RTL and testbench

COMPRESSED_PACKER -- requirements
Module: compressed_packer

---
 rtl/compressed_packer_if.sv | 33 +++
 rtl/compressed_packer.sv | 181 ++++++++++++++++++
 tb/tb_compressed_packer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compressed_packer_if.sv
// Segment-in / packet-out bus of compressed_packer.
// The slave modport is the packer's view; the master modport is the producer/consumer side.
interface compressed_packer_if #(
   parameter int WORD_WIDTH = 32,
   parameter int PACK_BYTES = 32
);
   localparam int MAX_SEGS = PACK_BYTES / 4;
   localparam int COUNT_W  = $clog2(MAX_SEGS + 1);
   localparam int FILL_W   = $clog2(PACK_BYTES + 1);

   logic                    seg_valid;
   logic                    seg_ready;
   logic [8*WORD_WIDTH-1:0] seg_data;
   logic [3:0]              seg_mode;
   logic                    seg_last;

   logic                    pack_valid;
   logic                    pack_ready;
   logic [8*PACK_BYTES-1:0] pack_data;
   logic [4*MAX_SEGS-1:0]   pack_mode;
   logic [COUNT_W-1:0]      pack_count;
   logic [FILL_W-1:0]       pack_fill;

   modport master (
      output seg_valid, seg_data, seg_mode, seg_last, pack_ready,
      input  seg_ready, pack_valid, pack_data, pack_mode, pack_count, pack_fill
   );

   modport slave (
      input  seg_valid, seg_data, seg_mode, seg_last, pack_ready,
      output seg_ready, pack_valid, pack_data, pack_mode, pack_count, pack_fill
   );
endinterface

// File: rtl/compressed_packer.sv
// Packs variable-size compressed segments into a PACK_BYTES-wide packet window.
// Optional statistics counters are enabled by defining COMPRESSED_PACKER_STATS_EN.
module compressed_packer #(
   parameter int         WORD_WIDTH    = 32,
   parameter int         PACK_BYTES    = 32,
   parameter logic [3:0] RPV4_CODE     = 4'b0000,
   parameter logic [3:0] RPV8_CODE     = 4'b0001,
   parameter logic [3:0] B8D1_CODE     = 4'b0010,
   parameter logic [3:0] B4D1_CODE     = 4'b0011,
   parameter logic [3:0] B8D4_CODE     = 4'b0100,
   parameter logic [3:0] B8D2_CODE     = 4'b0101,
   parameter logic [3:0] B4D2_CODE     = 4'b0110,
   parameter logic [3:0] B2D1_CODE     = 4'b0111,
   parameter logic [3:0] NO_COMPR_CODE = 4'b1111
) (
   input  logic        clk,
   input  logic        rst,
`ifdef COMPRESSED_PACKER_STATS_EN
   output logic [31:0] stat_segs,
   output logic [31:0] stat_packs,
   output logic [31:0] stat_bytes_saved,
`endif
   compressed_packer_if.slave bus
);
   localparam int MAX_SEGS   = PACK_BYTES / 4;
   localparam int SEG_BYTES  = WORD_WIDTH;
   localparam int SEG_W      = 8 * WORD_WIDTH;
   localparam int PACK_W     = 8 * PACK_BYTES;
   localparam int MODE_W     = 4 * MAX_SEGS;
   localparam int COUNT_W    = $clog2(MAX_SEGS + 1);
   localparam int FILL_W     = $clog2(PACK_BYTES + 1);
   localparam int COPY_BYTES = (SEG_BYTES < 32) ? SEG_BYTES : 32;

   typedef enum logic {FILL, EMIT} state_t;

   function automatic logic [5:0] size_of(input logic [3:0] mode);
      case (mode)
         RPV4_CODE:            size_of = 6'd4;
         RPV8_CODE:            size_of = 6'd8;
         B8D1_CODE, B4D1_CODE: size_of = 6'd12;
         B8D2_CODE:            size_of = 6'd16;
         B2D1_CODE:            size_of = 6'd18;
         B4D2_CODE:            size_of = 6'd20;
         B8D4_CODE:            size_of = 6'd24;
         NO_COMPR_CODE:        size_of = 6'd32;
         default:              size_of = 6'd32;
      endcase
   endfunction

   // Keeps only the low `size` bytes so unused window bytes stay zero.
   function automatic logic [PACK_W-1:0] trim(input logic [SEG_W-1:0] data, input logic [5:0] size);
      trim = '0;
      for (int b = 0; b < COPY_BYTES; b++)
         if (b < int'(size)) trim[8*b +: 8] = data[8*b +: 8];
   endfunction

   function automatic logic [MODE_W-1:0] slot(input logic [COUNT_W-1:0] idx, input logic [3:0] mode);
      slot = '0;
      for (int s = 0; s < MAX_SEGS; s++)
         if (idx == COUNT_W'(s)) slot[4*s +: 4] = mode;
   endfunction

   state_t             state, state_nxt;
   logic [PACK_W-1:0]  buf_data, buf_data_nxt;
   logic [MODE_W-1:0]  buf_mode, buf_mode_nxt;
   logic [FILL_W-1:0]  fill, fill_nxt;
   logic [COUNT_W-1:0] count, count_nxt;
   logic               pend_valid, pend_valid_nxt;
   logic [SEG_W-1:0]   pend_data, pend_data_nxt;
   logic [3:0]         pend_mode, pend_mode_nxt;
   logic               pend_last, pend_last_nxt;

   logic [5:0]         seg_size, pend_size;
   logic [FILL_W:0]    fill_sum;
   logic               accept, emit_hs, fits;
   logic [PACK_W-1:0]  seg_placed;

   assign seg_size   = size_of(bus.seg_mode);
   assign pend_size  = size_of(pend_mode);
   assign accept     = bus.seg_valid && (state == FILL);
   assign emit_hs    = bus.pack_ready && (state == EMIT);
   assign fill_sum   = {1'b0, fill} + (FILL_W+1)'(seg_size);
   assign fits       = fill_sum <= (FILL_W+1)'(PACK_BYTES);
   assign seg_placed = trim(bus.seg_data, seg_size) << {fill, 3'b000};

   // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_nxt      = state;
      buf_data_nxt   = buf_data;
      buf_mode_nxt   = buf_mode;
      fill_nxt       = fill;
      count_nxt      = count;
      pend_valid_nxt = pend_valid;
      pend_data_nxt  = pend_data;
      pend_mode_nxt  = pend_mode;
      pend_last_nxt  = pend_last;
      case (state)
         FILL: begin
            if (accept && fits) begin
               buf_data_nxt = buf_data | seg_placed;
               buf_mode_nxt = buf_mode | slot(count, bus.seg_mode);
               fill_nxt     = fill + FILL_W'(seg_size);
               count_nxt    = count + COUNT_W'(1);
               if (bus.seg_last) state_nxt = EMIT;
            end else if (accept) begin
               pend_valid_nxt = 1'b1;
               pend_data_nxt  = bus.seg_data;
               pend_mode_nxt  = bus.seg_mode;
               pend_last_nxt  = bus.seg_last;
               state_nxt      = EMIT;
            end
         end
         EMIT: begin
            if (emit_hs && pend_valid) begin
               // The held-back segment always fits an empty window.
               buf_data_nxt   = trim(pend_data, pend_size);
               buf_mode_nxt   = {{(MODE_W-4){1'b0}}, pend_mode};
               fill_nxt       = FILL_W'(pend_size);
               count_nxt      = COUNT_W'(1);
               pend_valid_nxt = 1'b0;
               state_nxt      = pend_last ? EMIT : FILL;
            end else if (emit_hs) begin
               buf_data_nxt = '0;
               buf_mode_nxt = '0;
               fill_nxt     = '0;
               count_nxt    = '0;
               state_nxt    = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         buf_data   <= '0;
         buf_mode   <= '0;
         fill       <= '0;
         count      <= '0;
         pend_valid <= 1'b0;
         pend_mode  <= '0;
         pend_last  <= 1'b0;
      end else begin
         state      <= state_nxt;
         buf_data   <= buf_data_nxt;
         buf_mode   <= buf_mode_nxt;
         fill       <= fill_nxt;
         count      <= count_nxt;
         pend_valid <= pend_valid_nxt;
         pend_mode  <= pend_mode_nxt;
         pend_last  <= pend_last_nxt;
      end
   end

   // NOTE: the wide pending payload is not reset; pend_valid alone qualifies it.
   always_ff @(posedge clk) pend_data <= pend_data_nxt;

`ifdef COMPRESSED_PACKER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_segs        <= '0;
         stat_packs       <= '0;
         stat_bytes_saved <= '0;
      end else begin
         if (accept) begin
            stat_segs        <= stat_segs + 32'd1;
            stat_bytes_saved <= stat_bytes_saved + 32'(6'd32 - seg_size);
         end
         if (emit_hs) stat_packs <= stat_packs + 32'd1;
      end
   end
`endif

   assign bus.seg_ready  = (state == FILL);
   assign bus.pack_valid = (state == EMIT);
   assign bus.pack_data  = buf_data;
   assign bus.pack_mode  = buf_mode;
   assign bus.pack_count = count;
   assign bus.pack_fill  = fill;
endmodule

// File: tb/tb_compressed_packer.sv
// Bench for compressed_packer: directed scenarios plus randomized traffic against a byte-level packing model.
// Stat counters are checked when COMPRESSED_PACKER_STATS_EN is defined.
module tb_compressed_packer;
   localparam int PB = 32;

   typedef struct {
      logic [255:0] data;
      logic [31:0]  mode;
      int           count;
      int           fill;
   } pkt_t;

   typedef struct {
      logic [255:0] data;
      logic [3:0]   mode;
      bit           last;
   } seg_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   compressed_packer_if #(.WORD_WIDTH(32), .PACK_BYTES(PB)) bus ();

`ifdef COMPRESSED_PACKER_STATS_EN
   logic [31:0] stat_segs, stat_packs, stat_bytes_saved;
`endif

   compressed_packer #(.WORD_WIDTH(32), .PACK_BYTES(PB)) dut (
      .clk              (clk),
      .rst              (rst),
`ifdef COMPRESSED_PACKER_STATS_EN
      .stat_segs        (stat_segs),
      .stat_packs       (stat_packs),
      .stat_bytes_saved (stat_bytes_saved),
`endif
      .bus              (bus)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   bit   auto_ready = 1'b0;

   logic [7:0]  m_buf [PB];
   logic [3:0]  m_modes [$];
   int          m_fill = 0;
   pkt_t        exp_q [$];
   pkt_t        got_q [$];
   int          m_segs = 0, m_packs = 0, m_saved = 0;

   task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int seg_bytes(logic [3:0] m);
      case (m)
         4'd0:       return 4;
         4'd1:       return 8;
         4'd2, 4'd3: return 12;
         4'd4:       return 24;
         4'd5:       return 16;
         4'd6:       return 20;
         4'd7:       return 18;
         default:    return 32;
      endcase
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic seg_t mk(logic [255:0] d, logic [3:0] m, bit l);
      seg_t s;
      s.data = d;
      s.mode = m;
      s.last = l;
      return s;
   endfunction

   function automatic void model_emit();
      pkt_t p;
      p.data = '0;
      p.mode = '0;
      for (int b = 0; b < m_fill; b++) p.data[8*b +: 8] = m_buf[b];
      for (int i = 0; i < m_modes.size(); i++) p.mode[4*i +: 4] = m_modes[i];
      p.count = m_modes.size();
      p.fill  = m_fill;
      exp_q.push_back(p);
      m_fill = 0;
      m_modes.delete();
   endfunction

   function automatic void model_push(seg_t s);
      int sz = seg_bytes(s.mode);
      if (m_fill + sz > PB) model_emit();
      for (int b = 0; b < sz; b++) m_buf[m_fill + b] = s.data[8*b +: 8];
      m_modes.push_back(s.mode);
      m_fill += sz;
      if (s.last) model_emit();
      m_segs++;
      m_saved += 32 - sz;
   endfunction

   task automatic send(seg_t s, int max_gap);
      int t = 0;
      model_push(s);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      bus.seg_valid = 1'b1;
      bus.seg_data  = s.data;
      bus.seg_mode  = s.mode;
      bus.seg_last  = s.last;
      while (!bus.seg_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!bus.seg_ready) check("seg_accept_timeout", t, 0);
      @(negedge clk);
      bus.seg_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || bus.pack_valid) && t < 600) begin
         @(negedge clk);
         t++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic check_pkt(string tag, int idx, int fill, int count, logic [31:0] mode);
      if (idx >= got_q.size()) check({tag, "_present"}, got_q.size(), idx + 1);
      else begin
         check({tag, "_fill"}, got_q[idx].fill, fill);
         check({tag, "_count"}, got_q[idx].count, count);
         check({tag, "_mode"}, got_q[idx].mode, mode);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.seg_valid = 1'b0;
      @(negedge clk);
      check("rst_pack_valid", bus.pack_valid, 0);
      check("rst_seg_ready", bus.seg_ready, 1);
      check("rst_fill", bus.pack_fill, 0);
      check("rst_count", bus.pack_count, 0);
      check("rst_data", bus.pack_data, 0);
      check("rst_mode", bus.pack_mode, 0);
`ifdef COMPRESSED_PACKER_STATS_EN
      check("rst_stat_segs", stat_segs, 0);
      check("rst_stat_packs", stat_packs, 0);
      check("rst_stat_saved", stat_bytes_saved, 0);
`endif
      rst = 1'b0;
      exp_q.delete();
      got_q.delete();
      m_modes.delete();
      m_fill  = 0;
      m_segs  = 0;
      m_packs = 0;
      m_saved = 0;
      @(negedge clk);
      check("post_rst_seg_ready", bus.seg_ready, 1);
   endtask

   // Packet side: random back-pressure, hold-stability and scoreboard compare.
   initial begin
      pkt_t prev, g, e;
      bit   prev_valid = 1'b0, prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_valid = 1'b0;
            continue;
         end
         if (auto_ready) bus.pack_ready = ($urandom_range(0, 2) != 0);
         check("ready_xor_valid", bus.seg_ready ^ bus.pack_valid, 1);
         g.data  = bus.pack_data;
         g.mode  = bus.pack_mode;
         g.count = int'(bus.pack_count);
         g.fill  = int'(bus.pack_fill);
         if (prev_valid && !prev_ready && bus.pack_valid) begin
            check("hold_data", g.data, prev.data);
            check("hold_mode", g.mode, prev.mode);
            check("hold_count", g.count, prev.count);
            check("hold_fill", g.fill, prev.fill);
         end
         if (bus.pack_valid && bus.pack_ready) begin
            got_q.push_back(g);
            m_packs++;
            if (exp_q.size() == 0) check("pack_expected", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               check("pack_data", g.data, e.data);
               check("pack_mode", g.mode, e.mode);
               check("pack_count", g.count, e.count);
               check("pack_fill", g.fill, e.fill);
            end
         end
         prev       = g;
         prev_valid = bus.pack_valid;
         prev_ready = bus.pack_ready;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] d;
      bus.seg_valid  = 1'b0;
      bus.seg_data   = '0;
      bus.seg_mode   = '0;
      bus.seg_last   = 1'b0;
      bus.pack_ready = 1'b0;
      do_reset();

      // Two RPV4 segments share one packet.
      auto_ready = 1'b1;
      d = rand256();
      d[31:0] = 32'hAABBCCDD;
      send(mk(d, 4'h0, 1'b0), 0);
      d = rand256();
      d[31:0] = 32'h11223344;
      send(mk(d, 4'h0, 1'b1), 0);
      drain();
      check_pkt("rpv4x2", 0, 8, 2, 32'h0);
      if (got_q.size() > 0) begin
         check("rpv4x2_low", got_q[0].data[63:0], 64'h11223344AABBCCDD);
         check("rpv4x2_high", got_q[0].data[255:64], 0);
      end
      got_q.delete();

      // Overflow goes to pending then its own packet.
      send(mk(rand256(), 4'h4, 1'b0), 1);
      send(mk(rand256(), 4'h6, 1'b1), 1);
      drain();
      check_pkt("b8d4", 0, 24, 1, 32'h4);
      check_pkt("b4d2", 1, 20, 1, 32'h6);
      got_q.delete();

      // Exact fit does not emit until the following segment.
      for (int i = 0; i < 8; i++) send(mk(rand256(), 4'h0, 1'b0), 1);
      send(mk(rand256(), 4'h0, 1'b1), 1);
      drain();
      check_pkt("exact_fit", 0, 32, 8, 32'h0);
      check_pkt("after_fit", 1, 4, 1, 32'h0);
      got_q.delete();

      // Unknown mode carries the full segment.
      d = rand256();
      send(mk(d, 4'hA, 1'b1), 0);
      drain();
      check_pkt("mode_a", 0, 32, 1, 32'hA);
      if (got_q.size() > 0) check("mode_a_data", got_q[0].data, d);
      got_q.delete();

      // Back-pressure stall in EMIT.
      auto_ready = 1'b0;
      bus.pack_ready = 1'b0;
      send(mk(rand256(), 4'h1, 1'b1), 0);
      check("emit_next_cycle", bus.pack_valid, 1);
      repeat (5) begin
         @(negedge clk);
         check("stall_seg_ready", bus.seg_ready, 0);
         check("stall_pack_valid", bus.pack_valid, 1);
      end
      bus.pack_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("stall_release_valid", bus.pack_valid, 0);
      check("stall_release_ready", bus.seg_ready, 1);
      bus.pack_ready = 1'b0;
      check_pkt("stall_pkt", 0, 8, 1, 32'h1);
      got_q.delete();

      // Reset while emitting with a pending segment discards both.
      send(mk(rand256(), 4'h4, 1'b0), 0);
      send(mk(rand256(), 4'h6, 1'b1), 0);
      check("pend_emit_valid", bus.pack_valid, 1);
      do_reset();
      auto_ready = 1'b1;
      send(mk(rand256(), 4'h0, 1'b1), 0);
      drain();
      check("after_rst_packets", got_q.size(), 1);
      check_pkt("after_rst", 0, 4, 1, 32'h0);
      got_q.delete();

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         send(mk(rand256(), 4'($urandom_range(0, 15)), (i == 399) || ($urandom_range(0, 4) == 0)), 2);
      drain();

`ifdef COMPRESSED_PACKER_STATS_EN
      check("stat_segs", stat_segs, m_segs);
      check("stat_packs", stat_packs, m_packs);
      check("stat_bytes_saved", stat_bytes_saved, m_saved);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
